// File: rtl/alu_pkg.sv
// Shared opcode/state types and constants for the multi-cycle ALU.
// The multiply/divide opcodes are only implemented when ALU_MULDIV_EN is defined.
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [3:0] {
        OP_ADD   = 4'b0000,
        OP_SUB   = 4'b0001,
        OP_AND   = 4'b0010,
        OP_OR    = 4'b0011,
        OP_XOR   = 4'b0100,
        OP_SLT   = 4'b0101,
        OP_SLTU  = 4'b0110,
        OP_SLL   = 4'b0111,
        OP_SRL   = 4'b1000,
        OP_SRA   = 4'b1001,
        OP_MUL   = 4'b1010,
        OP_MULHU = 4'b1011,
        OP_DIV   = 4'b1100,
        OP_DIVU  = 4'b1101,
        OP_REM   = 4'b1110,
        OP_REMU  = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    // Opcodes 1010..1111 are the iterative multiply/divide group.
    function automatic logic is_muldiv(alu_op_e op);
        return op[3] & (op[2] | op[1]);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply/divide unit: one bit per cycle, shift-add multiply and
// restoring division on magnitudes. Only built when ALU_MULDIV_EN is defined.
`ifdef ALU_MULDIV_EN
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  alu_op_e         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    logic              busy_q, busy_d;
    logic [SHW-1:0]    cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;
    logic [XLEN-1:0]   a_q, a_d;
    alu_op_e           op_q, op_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic              div0_q, div0_d;

    logic              signed_op, a_neg, b_neg, start_mul, run_mul, last;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next, div_next;
    logic [XLEN:0]     partial;
    logic [XLEN-1:0]   diff_lo, rem_next;
    logic              ge;
    logic [XLEN-1:0]   quo_fin, rem_fin;

    always_comb begin
        signed_op = (op == OP_DIV) || (op == OP_REM);
        a_neg     = signed_op && a[XLEN-1];
        b_neg     = signed_op && b[XLEN-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
        start_mul = (op == OP_MUL) || (op == OP_MULHU);
        run_mul   = (op_q == OP_MUL) || (op_q == OP_MULHU);
        last      = (cnt_q == SHW'(XLEN - 1));
    end

    // acc holds {hi, lo}: product during multiply, {remainder, quotient} during divide.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        partial  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        ge       = partial[XLEN] || (partial[XLEN-1:0] >= dvs_q);
        diff_lo  = partial[XLEN-1:0] - dvs_q;
        rem_next = ge ? diff_lo : partial[XLEN-1:0];
        div_next = {rem_next, acc_q[XLEN-2:0], ge};
    end

    always_comb begin
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        dvs_d     = dvs_q;
        a_d       = a_q;
        op_d      = op_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        if (start) begin
            busy_d    = 1'b1;
            cnt_d     = '0;
            op_d      = op;
            a_d       = a;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            div0_d    = !start_mul && (b == '0);
            acc_d     = start_mul ? {{XLEN{1'b0}}, b} : {{XLEN{1'b0}}, a_mag};
            dvs_d     = start_mul ? a : b_mag;
        end else if (busy_q) begin
            acc_d = run_mul ? mul_next : div_next;
            cnt_d = cnt_q + SHW'(1);
            if (last) begin
                busy_d = 1'b0;
            end
        end
    end

    // Result is taken from the final step's next value so the caller can finish on the last count.
    always_comb begin
        quo_fin = acc_d[XLEN-1:0];
        rem_fin = acc_d[2*XLEN-1:XLEN];
        result  = '0;
        case (op_q)
            OP_MUL:           result = quo_fin;
            OP_MULHU:         result = rem_fin;
            OP_DIV, OP_DIVU:  result = div0_q ? '1 : (neg_quo_q ? -quo_fin : quo_fin);
            OP_REM, OP_REMU:  result = div0_q ? a_q : (neg_rem_q ? -rem_fin : rem_fin);
            default:          result = '0;
        endcase
    end

    assign done = busy_q && last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            dvs_q     <= '0;
            a_q       <= '0;
            op_q      <= OP_ADD;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            dvs_q     <= dvs_d;
            a_q       <= a_d;
            op_q      <= op_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
        end
    end

endmodule
`endif

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU with valid/ready handshakes on both sides.
// Define ALU_MULDIV_EN to build the iterative multiply/divide unit; otherwise those opcodes flag illegal.
module alu_mc
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      ctrl,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rd,
    output logic            z,
    output logic            illegal
);

    alu_state_e      state_q, state_d;
    logic [XLEN-1:0] rd_q, rd_d;
    logic            z_q, z_d;
    logic            illegal_q, illegal_d;
    alu_op_e         op_in;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_res;

    assign op_in = alu_op_e'(ctrl);
    assign shamt = rs2[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (op_in)
            OP_ADD:  alu_res = rs1 + rs2;
            OP_SUB:  alu_res = rs1 - rs2;
            OP_AND:  alu_res = rs1 & rs2;
            OP_OR:   alu_res = rs1 | rs2;
            OP_XOR:  alu_res = rs1 ^ rs2;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(rs1) < $signed(rs2)};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, rs1 < rs2};
            OP_SLL:  alu_res = rs1 << shamt;
            OP_SRL:  alu_res = rs1 >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(rs1) >>> shamt);
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_MULDIV_EN
    logic            md_start, md_done;
    logic [XLEN-1:0] md_result;

    assign md_start = (state_q == IDLE) && in_valid && is_muldiv(op_in);

    alu_muldiv_iter #(
        .XLEN (XLEN),
        .SHW  (SHW)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .op     (op_in),
        .a      (rs1),
        .b      (rs2),
        .done   (md_done),
        .result (md_result)
    );
`endif

    always_comb begin
        state_d   = state_q;
        rd_d      = rd_q;
        z_d       = z_q;
        illegal_d = illegal_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (is_muldiv(op_in)) begin
`ifdef ALU_MULDIV_EN
                        state_d = BUSY;
`else
                        rd_d      = '0;
                        z_d       = 1'b1;
                        illegal_d = 1'b1;
                        state_d   = DONE;
`endif
                    end else begin
                        rd_d      = alu_res;
                        z_d       = (alu_res == '0);
                        illegal_d = 1'b0;
                        state_d   = DONE;
                    end
                end
            end
            BUSY: begin
`ifdef ALU_MULDIV_EN
                if (md_done) begin
                    rd_d      = md_result;
                    z_d       = (md_result == '0);
                    illegal_d = 1'b0;
                    state_d   = DONE;
                end
`else
                state_d = IDLE;
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rd_q      <= '0;
            z_q       <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_d;
            z_q       <= z_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign rd        = rd_q;
    assign z         = z_q;
    assign illegal   = illegal_q;

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the single-cycle core ALU.
- Adds valid/ready handshakes on operand and result sides, a 4-bit opcode space, shifts, XOR and unsigned compare.
- Adds an iterative multiply/divide unit (RV32M-style subset).
- Sits in the execute stage; the pipeline stalls while in_ready or out_valid is low.

Parameters:
- XLEN, 32, operand/result width; power of two, >= 8.
- SHW, $clog2(XLEN), shift-amount width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands/ctrl valid.
- in_ready  out  1  block can accept an operation.
- ctrl  in  4  opcode (see Behaviour).
- rs1  in  XLEN  operand a.
- rs2  in  XLEN  operand b.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- rd  out  XLEN  result.
- z  out  1  rd == 0; valid with out_valid.
- illegal  out  1  opcode unsupported in this build; valid with out_valid.

Behaviour:
- Opcodes:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt (signed), 0110 sltu, 0111 sll.
  - 1000 srl, 1001 sra, 1010 mul (low XLEN), 1011 mulhu (high XLEN, unsigned).
  - 1100 div, 1101 divu, 1110 rem, 1111 remu.
  - Codes 0000-0011 and 0101 keep the legacy 3-bit values zero-extended.
- Shifts use rs2[SHW-1:0] only. add/sub wrap modulo 2^XLEN. slt/sltu return 0 or 1.
- FSM states: IDLE, BUSY, DONE.
  - in_ready = (state == IDLE). out_valid = (state == DONE).
  - IDLE with in_valid: latch ctrl/rs1/rs2. Simple op -> DONE next cycle (latency 1). Mul/div op -> BUSY.
  - BUSY: iteration counter runs 0..XLEN-1, one bit per cycle. Shift-add multiply into a 2*XLEN accumulator; restoring division on magnitudes. At count XLEN-1 -> DONE. Mul/div latency is XLEN+1 cycles from accept to out_valid.
  - DONE: rd, z and illegal held stable until out_ready. On out_valid && out_ready -> IDLE. No accept in the same cycle; throughput is 1 op per 2 cycles minimum.
- Signed division: operate on |rs1| and |rs2|. Quotient negated if signs differ; remainder takes the sign of rs1.
- Division by zero: quotient = all ones, remainder = rs1, in all four ops. Takes the full XLEN+1 latency.
- Overflow (div, rs1 = -2^(XLEN-1), rs2 = -1): quotient = rs1, rem = 0.
- Inputs change while BUSY or DONE: ignored. Operands are latched at accept.
- Reset, any state including mid-iteration: state IDLE, rd = 0, z = 0, illegal = 0, out_valid = 0, counter = 0, accumulators = 0. in_ready = 1 after reset deasserts. The partial result is discarded.
- rd and z are registered outputs; no combinational path from inputs to outputs except through the FSM.

Optional Feature:
- Macro ALU_MULDIV_EN.
- Defined: opcodes 1010-1111 implemented as above; illegal is never asserted.
- Undefined:
  - No multiply/divide datapath and no BUSY state is instantiated.
  - Opcodes 1010-1111 complete in 1 cycle with rd = 0, z = 1, illegal = 1.
  - Port list is unchanged.

Decomposition:
- Package alu_pkg:
  - alu_op_e (4-bit enum, the opcodes above).
  - alu_state_e (IDLE/BUSY/DONE).
  - Helper function is_muldiv(op).
  - Default XLEN constant.
- One sub-module, alu_muldiv_iter:
  - Holds the counter, accumulators and sign fix-up.
  - Start/done pulse interface to alu_mc.
  - Instantiated only under ALU_MULDIV_EN.

Test Plan:
- Simple-op sweep, XLEN=32: add 20+30 -> rd=50, 1 cycle after accept. sub 8-3 -> 5. and 20&30 -> 20. or -> 30. xor -> 10. slt 20<30 -> 1. sltu 0xFFFFFFFF<1 -> 0. sra 0x80000000>>4 -> 0xF8000000. sub 20-20 -> z=1.
- Multiply: mul 0x12345678 * 0x10 -> 0x23456780. mulhu 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE. out_valid exactly 33 cycles after accept.
- Divide corners: div -7/2 -> -3. rem -7/2 -> -1. divu 10/0 -> 0xFFFFFFFF. rem 10/0 -> 10. div 0x80000000/-1 -> 0x80000000, rem 0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> rd/z stable, in_ready=0. Then pulse out_ready -> IDLE, in_ready=1 next cycle.
- Reset mid-op: assert rst at cycle 10 of a divu -> out_valid=0, rd=0 immediately (async). A new add 1+1 after release -> 2.
- Build without ALU_MULDIV_EN: mul 3*3 -> rd=0, z=1, illegal=1 in 1 cycle. add 1+1 -> 2, illegal=0.
